// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (CPU) and the loader/dump DMA port.
// CPU wins by default; DMA is forced through after MAX_WAIT consecutive losing cycles.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {StIdle, StRdWait} rdStateT;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  rdStateT    state, stateNext;
  logic       rdOwner, rdOwnerNext;  // 0 = CPU, 1 = DMA
  logic [3:0] waitCnt, waitCntNext;
  logic       forceDma;
  logic       rdGrant;

  // Grant and memory-side mux
  always_comb begin
    forceDma  = dma_req && (waitCnt == MaxWait);
    dma_gnt   = dma_req && (!cpu_req || forceDma);
    cpu_gnt   = cpu_req && !dma_gnt;
    cpu_stall = cpu_req && !cpu_gnt;
    mem_en    = cpu_gnt || dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Starvation counter saturates at MaxWait; any DMA grant or idle DMA clears it
  always_comb begin
    waitCntNext = 4'd0;
    if (dma_req && !dma_gnt) begin
      waitCntNext = (waitCnt >= MaxWait) ? MaxWait : waitCnt + 4'd1;
    end
  end

  // Read-return tracking: remember who issued the read granted this cycle
  always_comb begin
    rdGrant     = (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
    stateNext   = StIdle;
    rdOwnerNext = rdOwner;
    if (rdGrant) begin
      stateNext   = StRdWait;
      rdOwnerNext = dma_gnt;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= StIdle;
      rdOwner <= 1'b0;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      rdOwner <= rdOwnerNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    cpu_rvalid = (state == StRdWait) && !rdOwner;
    dma_rvalid = (state == StRdWait) && rdOwner;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [4:0]  dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] memArr [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) memArr[mem_addr] <= mem_wdata;
      else        mem_rdata <= memArr[mem_addr];
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [4:0] da,
                       input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic expD, expRv;
    rstN = 1'b0;
    // Reset with both ports requesting (CPU write, so nothing to read back)
    drive(1, 1, 5'd31, 32'h0, 1, 0, 5'd0, 32'h0);
    checkEq("rst_cpu_rvalid", cpu_rvalid, 0);
    checkEq("rst_dma_rvalid", dma_rvalid, 0);
    checkEq("rst_cpu_rdata", cpu_rdata, 0);
    checkEq("rst_dma_rdata", dma_rdata, 0);
    tick();
    rstN = 1'b1;
    #1;
    checkEq("rel_cpu_gnt", cpu_gnt, 1);
    checkEq("rel_dma_gnt", dma_gnt, 0);
    tick();
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
    checkEq("rel_no_rvalid", cpu_rvalid, 0);
    tick();

    // DMA preload 0xAA..0xB1 into addr 0..7
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 5'd0, 32'h0, 1, 1, 5'(i), 32'hAA + 32'(i));
      checkEq("pre_dma_gnt", dma_gnt, 1);
      checkEq("pre_mem_we", mem_we, 1);
      checkEq("pre_mem_addr", mem_addr, 32'(i));
      checkEq("pre_mem_wdata", mem_wdata, 32'hAA + 32'(i));
      checkEq("pre_rvalid", {cpu_rvalid, dma_rvalid}, 0);
      tick();
    end

    // CPU read of addr 3
    drive(1, 0, 5'd3, 32'h0, 0, 0, 5'd0, 32'h0);
    checkEq("rd_cpu_gnt", cpu_gnt, 1);
    checkEq("rd_mem_we", mem_we, 0);
    tick();
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
    checkEq("rd_cpu_rvalid", cpu_rvalid, 1);
    checkEq("rd_cpu_rdata", cpu_rdata, 32'hAD);
    checkEq("rd_dma_rvalid", dma_rvalid, 0);
    checkEq("idle_mem_addr", mem_addr, 0);
    tick();
    checkEq("rd_one_cycle", cpu_rvalid, 0);
    checkEq("rd_rdata_zero", cpu_rdata, 0);

    // Starvation: both requesting for 12 cycles, DMA forced at cycles 4 and 9
    for (int c = 0; c < 12; c++) begin
      drive(1, 0, 5'd0, 32'h0, 1, 0, 5'd5, 32'h0);
      expD  = (c == 4) || (c == 9);
      expRv = (c == 5) || (c == 10);
      checkEq("stv_dma_gnt", dma_gnt, expD);
      checkEq("stv_cpu_gnt", cpu_gnt, !expD);
      checkEq("stv_cpu_stall", cpu_stall, expD);
      checkEq("stv_dma_rvalid", dma_rvalid, expRv);
      checkEq("stv_dma_rdata", dma_rdata, expRv ? 32'hAF : 32'h0);
      checkEq("stv_cpu_rvalid", cpu_rvalid, (c > 0) && !expRv);
      if ((c > 0) && !expRv) checkEq("stv_cpu_rdata", cpu_rdata, 32'hAA);
      tick();
    end
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
    checkEq("stv_last_cpu_rv", cpu_rvalid, 1);
    tick();

    // Interleaved: CPU read addr 1 at N=3, forced DMA read addr 2 at N+1
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 5'd1, 32'h0, 1, 0, 5'd2, 32'h0);
      checkEq("il_dma_gnt", dma_gnt, c == 4);
      if (c == 4) begin
        checkEq("il_cpu_rvalid", cpu_rvalid, 1);
        checkEq("il_cpu_rdata", cpu_rdata, 32'hAB);
      end
      tick();
    end
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
    checkEq("il_dma_rvalid", dma_rvalid, 1);
    checkEq("il_dma_rdata", dma_rdata, 32'hAC);
    checkEq("il_cpu_rv_off", cpu_rvalid, 0);
    tick();

    // Read-after-write in consecutive CPU grants
    drive(1, 1, 5'd10, 32'h1234_5678, 0, 0, 5'd0, 32'h0);
    checkEq("raw_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    drive(1, 0, 5'd10, 32'h0, 0, 0, 5'd0, 32'h0);
    checkEq("raw_no_rv_write", cpu_rvalid, 0);
    tick();
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
    checkEq("raw_rdata", cpu_rdata, 32'h1234_5678);
    tick();

    // Reset mid-read with a partly filled starvation counter
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 5'd4, 32'h0, 1, 0, 5'd6, 32'h0);
      tick();
    end
    drive(1, 0, 5'd4, 32'h0, 1, 0, 5'd6, 32'h0);
    checkEq("mid_cpu_gnt", cpu_gnt, 1);
    rstN = 1'b0;
    tick();
    checkEq("mid_rst_cpu_rv", cpu_rvalid, 0);
    checkEq("mid_rst_rdata", cpu_rdata, 0);
    tick();
    rstN = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 5'd4, 32'h0, 1, 0, 5'd6, 32'h0);
      if (c == 0) checkEq("post_rst_cpu_rv", cpu_rvalid, 0);
      checkEq("post_rst_dma_gnt", dma_gnt, c == 4);
      tick();
    end
    checkEq("post_rst_dma_rv", dma_rvalid, 1);
    checkEq("post_rst_dma_rd", dma_rdata, 32'hB0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 32-word data memory between the pipeline MEM stage (CPU port) and a loader/dump DMA port used to preload and read back memory around a program run. CPU has fixed priority; a starvation counter forces a DMA grant after MAX_WAIT consecutive losing cycles. Read data returns one cycle after grant and is routed back to the requester that issued it. Sits between the pipeline MEM stage / loader and the data memory array.

Parameters:
DATA_W, 32, data word width
ADDR_W, 5, word address width (32 words)
MAX_WAIT, 4, consecutive DMA-losing cycles before DMA is forced (1..15)

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes pipeline
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
dma_req  in  1  DMA access request
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA word address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access accepted this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DATA_W  DMA read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, registered (valid cycle after mem_en & ~mem_we)

Behaviour:
- Reset (rstN=0, async): wait_cnt=0, rd_pend=0, rd_owner=CPU; cpu_rvalid=dma_rvalid=0, cpu_rdata=dma_rdata=0. Combinational outputs follow the rules below with registered state at reset values.
- Grant (combinational, same cycle as request):
  - force = dma_req & (wait_cnt == MAX_WAIT).
  - dma_gnt = dma_req & (~cpu_req | force); cpu_gnt = cpu_req & ~dma_gnt.
  - At most one grant per cycle; mem_en = cpu_gnt | dma_gnt; mem_we/addr/wdata muxed from granted port; when neither granted, mem_we=0, mem_addr=0, mem_wdata=0.
- Starvation counter wait_cnt (4 bits), per rising edge:
  - dma_req & ~dma_gnt: wait_cnt = min(wait_cnt+1, MAX_WAIT).
  - dma_gnt or ~dma_req: wait_cnt = 0.
- Read return FSM, states IDLE / RD_WAIT:
  - Granted read (gnt & ~we): next state RD_WAIT, rd_owner = granted port.
  - RD_WAIT: rvalid of rd_owner = 1 and its rdata = mem_rdata for exactly that cycle; other port rvalid=0. Back-to-back reads stay in RD_WAIT, owner updated each grant.
  - No read grant: IDLE. Writes produce no rvalid.
  - rdata outputs are combinational from mem_rdata while rvalid=1, hold 0 otherwise.
- Latency: write committed at edge ending the grant cycle; read data at cycle N+1 for grant at N. Read-after-write to same address in consecutive grants returns new data.
- Boundaries:
  - Both requests every cycle, MAX_WAIT=4: CPU granted 4 cycles, DMA 1, repeating (period 5).
  - DMA dropping req clears counter; no grant memory retained.
  - Reset mid-read: pending rvalid suppressed, no rvalid after rstN rises.
  - A stalled CPU keeps its request; no request queueing inside the block.

Test Plan:
- Reset: rstN=0 with both reqs high -> cpu_rvalid=dma_rvalid=0, rdata=0; after release, cpu_gnt=1, dma_gnt=0 first cycle.
- DMA preload: dma writes 0x0000_00AA..0x0000_00B1 to addr 0..7, cpu_req=0 -> dma_gnt=1 every cycle, mem_we=1, 8 writes, no rvalid.
- CPU read: cpu read addr 3 after preload -> cpu_gnt=1 at N, cpu_rvalid=1 with cpu_rdata=0xAD at N+1, dma_rvalid=0.
- Starvation: cpu_req and dma_req (read addr 5) held 12 cycles, MAX_WAIT=4 -> dma_gnt at cycles 4 and 9 only, cpu_stall=1 those cycles, dma_rvalid with 0xAF next cycle each time.
- Interleaved reads: CPU read addr 1 at N, forced DMA read addr 2 at N+1 -> cpu_rvalid/0xAB at N+1, dma_rvalid/0xAC at N+2.
- Reset mid-operation: CPU read granted, rstN=0 before next edge -> no cpu_rvalid, wait_cnt=0 after release.
